// File: rtl/fd_reg.sv
// Fetch/decode pipeline register with stall hold, flush bubble, AdEL tagging,
// a small RUN/HOLD/BUBBLE tracker FSM and a saturating stall counter.
module fd_reg (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] instr_f,
    input  logic [31:0] pc4_f,
    input  logic        wapc_f,
    input  logic        bd_f,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] ir_d,
    output logic [31:0] pc4_d,
    output logic [31:0] pc_d,
    output logic [4:0]  exc_d,
    output logic        bd_d,
    output logic        valid_d,
    output logic [1:0]  st,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HOLD    = 2'd1,
        ST_BUBBLE  = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

    localparam logic [31:0] RESET_PC4   = 32'h0000_3004;
    localparam logic [31:0] HANDLER_PC4 = 32'h0000_4184;
    localparam logic [4:0]  EXC_NONE    = 5'd0;
    localparam logic [4:0]  EXC_ADEL    = 5'd4;

    state_t      state_q, state_d;
    logic [31:0] dec_ir_q, dec_ir_d;
    logic [31:0] dec_pc4_q, dec_pc4_d;
    logic [4:0]  dec_exc_q, dec_exc_d;
    logic        dec_bd_q, dec_bd_d;
    logic        dec_valid_q, dec_valid_d;
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        state_d     = state_q;
        dec_ir_d    = dec_ir_q;
        dec_pc4_d   = dec_pc4_q;
        dec_exc_d   = dec_exc_q;
        dec_bd_d    = dec_bd_q;
        dec_valid_d = dec_valid_q;
        cnt_d       = cnt_q;

        if (stall && !flush && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end

        // The illegal encoding recovers by forcing a plain load into RUN.
        if (flush && (state_q != ST_ILLEGAL)) begin
            state_d     = ST_BUBBLE;
            dec_ir_d    = 32'h0;
            dec_pc4_d   = HANDLER_PC4;
            dec_exc_d   = EXC_NONE;
            dec_bd_d    = 1'b0;
            dec_valid_d = 1'b0;
        end else if (stall && (state_q != ST_ILLEGAL)) begin
            state_d = ST_HOLD;
        end else begin
            state_d     = ST_RUN;
            dec_ir_d    = wapc_f ? 32'h0 : instr_f;
            dec_pc4_d   = pc4_f;
            dec_exc_d   = wapc_f ? EXC_ADEL : EXC_NONE;
            dec_bd_d    = bd_f;
            dec_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= ST_BUBBLE;
            dec_ir_q    <= 32'h0;
            dec_pc4_q   <= RESET_PC4;
            dec_exc_q   <= EXC_NONE;
            dec_bd_q    <= 1'b0;
            dec_valid_q <= 1'b0;
            cnt_q       <= 16'h0;
        end else begin
            state_q     <= state_d;
            dec_ir_q    <= dec_ir_d;
            dec_pc4_q   <= dec_pc4_d;
            dec_exc_q   <= dec_exc_d;
            dec_bd_q    <= dec_bd_d;
            dec_valid_q <= dec_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ir_d      = dec_ir_q;
    assign pc4_d     = dec_pc4_q;
    assign pc_d      = dec_pc4_q - 32'd4;
    assign exc_d     = dec_exc_q;
    assign bd_d      = dec_bd_q;
    assign valid_d   = dec_valid_q;
    assign st        = state_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fd_reg.sv
// Randomized self-checking bench for fd_reg against a behavioural model of the
// fetch/decode register rules.
module tb_fd_reg;

    logic        clk;
    logic        clr;
    logic [31:0] instr_f;
    logic [31:0] pc4_f;
    logic        wapc_f;
    logic        bd_f;
    logic        stall;
    logic        flush;
    logic [31:0] ir_d;
    logic [31:0] pc4_d;
    logic [31:0] pc_d;
    logic [4:0]  exc_d;
    logic        bd_d;
    logic        valid_d;
    logic [1:0]  st;
    logic [15:0] stall_cnt;

    int checks;
    int errors;

    logic [31:0] m_ir;
    logic [31:0] m_pc4;
    logic [4:0]  m_exc;
    logic        m_bd;
    logic        m_valid;
    logic [1:0]  m_st;
    int          m_cnt;

    fd_reg dut (
        .clk       (clk),
        .clr       (clr),
        .instr_f   (instr_f),
        .pc4_f     (pc4_f),
        .wapc_f    (wapc_f),
        .bd_f      (bd_f),
        .stall     (stall),
        .flush     (flush),
        .ir_d      (ir_d),
        .pc4_d     (pc4_d),
        .pc_d      (pc_d),
        .exc_d     (exc_d),
        .bd_d      (bd_d),
        .valid_d   (valid_d),
        .st        (st),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc4, input logic wapc,
                                 input logic bd, input logic stl, input logic fl);
        instr_f = instr;
        pc4_f   = pc4;
        wapc_f  = wapc;
        bd_f    = bd;
        stall   = stl;
        flush   = fl;
    endtask

    task automatic modelReset();
        m_ir    = 32'h0;
        m_pc4   = 32'h0000_3004;
        m_exc   = 5'd0;
        m_bd    = 1'b0;
        m_valid = 1'b0;
        m_st    = 2'd2;
        m_cnt   = 0;
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".ir_d"},      ir_d,                m_ir);
        checkOutput({tag, ".pc4_d"},     pc4_d,               m_pc4);
        checkOutput({tag, ".pc_d"},      pc_d,                m_pc4 - 32'd4);
        checkOutput({tag, ".exc_d"},     {27'd0, exc_d},      {27'd0, m_exc});
        checkOutput({tag, ".bd_d"},      {31'd0, bd_d},       {31'd0, m_bd});
        checkOutput({tag, ".valid_d"},   {31'd0, valid_d},    {31'd0, m_valid});
        checkOutput({tag, ".st"},        {30'd0, st},         {30'd0, m_st});
        checkOutput({tag, ".stall_cnt"}, {16'd0, stall_cnt},  m_cnt);
    endtask

    // One rising edge: advance the model from the inputs present at the edge.
    task automatic clockEdge(input string tag, input bit doCheck);
        @(posedge clk);
        if (flush) begin
            m_ir = 32'h0; m_exc = 5'd0; m_bd = 1'b0; m_valid = 1'b0;
            m_pc4 = 32'h0000_4184; m_st = 2'd2;
        end else if (stall) begin
            m_st = 2'd1;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end else begin
            m_ir    = wapc_f ? 32'h0 : instr_f;
            m_exc   = wapc_f ? 5'd4 : 5'd0;
            m_pc4   = pc4_f;
            m_bd    = bd_f;
            m_valid = 1'b1;
            m_st    = 2'd0;
        end
        #1;
        if (doCheck) checkAll(tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clr = 1'b0;
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        modelReset();
        #12;
        checkAll("reset");
        checkOutput("reset.pc_d_abs", pc_d, 32'h0000_3000);
        clr = 1'b1;

        applyStimulus(32'h3c01_1234, 32'h0000_3004, 1'b0, 1'b0, 1'b0, 1'b0);
        clockEdge("first_load", 1'b1);
        checkOutput("first_load.pc_abs", pc_d, 32'h0000_3000);

        applyStimulus(32'hdead_beef, 32'h0000_3003, 1'b1, 1'b1, 1'b0, 1'b0);
        clockEdge("adel", 1'b1);
        checkOutput("adel.pc_abs", pc_d, 32'h0000_2fff);
        checkOutput("adel.exc_abs", {27'd0, exc_d}, 32'd4);

        applyStimulus(32'h2408_0001, 32'h0000_3008, 1'b0, 1'b0, 1'b0, 1'b0);
        clockEdge("load2", 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus($urandom, $urandom, 1'b0, 1'b1, 1'b1, 1'b0);
            clockEdge("hold", 1'b1);
        end
        checkOutput("hold.ir_abs", ir_d, 32'h2408_0001);
        checkOutput("hold.cnt_abs", {16'd0, stall_cnt}, 32'd3);
        applyStimulus(32'h2409_0002, 32'h0000_300c, 1'b0, 1'b0, 1'b0, 1'b0);
        clockEdge("unhold", 1'b1);

        applyStimulus(32'h1111_2222, 32'h0000_3010, 1'b0, 1'b1, 1'b1, 1'b1);
        clockEdge("stall_flush", 1'b1);
        checkOutput("stall_flush.pc_abs", pc_d, 32'h0000_4180);
        checkOutput("stall_flush.cnt_abs", {16'd0, stall_cnt}, 32'd3);

        applyStimulus(32'h3333_4444, 32'h0000_3014, 1'b0, 1'b0, 1'b1, 1'b0);
        clockEdge("bubble_hold", 1'b1);
        applyStimulus(32'h3333_4444, 32'h0000_3014, 1'b0, 1'b0, 1'b0, 1'b0);
        clockEdge("bubble_run", 1'b1);

        applyStimulus(32'h5555_6666, 32'h0000_3018, 1'b0, 1'b0, 1'b1, 1'b0);
        clockEdge("pre_async", 1'b1);
        #2;
        clr = 1'b0;
        modelReset();
        #1;
        checkAll("async_clr");
        #2;
        clr = 1'b1;
        applyStimulus(32'h7777_8888, 32'h0000_3020, 1'b0, 1'b0, 1'b0, 1'b0);
        clockEdge("after_clr", 1'b1);

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom, $urandom, ($urandom_range(3) == 0), $urandom_range(1),
                          ($urandom_range(2) == 0), ($urandom_range(7) == 0));
            clockEdge("random", 1'b1);
        end

        #2;
        clr = 1'b0;
        modelReset();
        #2;
        clr = 1'b1;
        applyStimulus(32'h0, 32'h0000_3004, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 65534; i++) clockEdge("preload", 1'b0);
        checkOutput("sat.preload", {16'd0, stall_cnt}, 32'h0000_fffe);
        for (int i = 0; i < 3; i++) clockEdge("sat", 1'b1);
        checkOutput("sat.cnt_abs", {16'd0, stall_cnt}, 32'h0000_ffff);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
